// File: rtl/div_pkg.sv
// Shared types for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } divState_e;

  // Step counter must hold WIDTH-1 with a spare bit.
  function automatic int cntWidth(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/adder_substractor.sv
// Ripple add/subtract unit; N is the borrow when subtracting, carry-out when adding.
module adder_substractor #(
  parameter int unsigned WIDTH = 5
) (
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             SUBS,
  output logic [WIDTH-1:0] S,
  output logic             N
);

  logic [WIDTH:0] full;

  assign full = {1'b0, A} + {1'b0, B ^ {WIDTH{SUBS}}} + {{WIDTH{1'b0}}, SUBS};
  assign S    = full[WIDTH-1:0];
  // Carry-out of A + ~B + 1 is the inverse of the borrow.
  assign N    = SUBS ? ~full[WIDTH] : full[WIDTH];

endmodule

// File: rtl/seq_divider.sv
// Sequential unsigned restoring divider, one quotient bit per cycle, MSB first.
module seq_divider
  import div_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);

  localparam int CntW = cntWidth(WIDTH);
  localparam logic [CntW-1:0] LastStep = CntW'(WIDTH - 1);

  divState_e state, stateNext;

  logic [CntW-1:0]  stepCnt, stepCntNext;
  logic [WIDTH-1:0] partRem, partRemNext;
  logic [WIDTH-1:0] shiftReg, shiftRegNext;
  logic [WIDTH-1:0] divisorReg, divisorRegNext;
  logic [WIDTH-1:0] quotNext, remNext;
  logic             dbzNext;

  logic [WIDTH:0]   trialA, trialB, diff, remWide;
  logic             borrow;
  logic [WIDTH-1:0] newRem, newShift;
  logic             unusedRemMsb;

  assign trialA = {partRem, shiftReg[WIDTH-1]};
  assign trialB = {1'b0, divisorReg};

  adder_substractor #(
    .WIDTH (WIDTH + 1)
  ) u_sub (
    .A    (trialA),
    .B    (trialB),
    .SUBS (1'b1),
    .S    (diff),
    .N    (borrow)
  );

  // Restoring step: keep the shifted value when the trial subtraction borrows.
  assign remWide      = borrow ? trialA : diff;
  assign newRem       = remWide[WIDTH-1:0];
  assign unusedRemMsb = remWide[WIDTH];
  assign newShift     = {shiftReg[WIDTH-2:0], ~borrow};

  always_comb begin
    stateNext      = state;
    stepCntNext    = stepCnt;
    partRemNext    = partRem;
    shiftRegNext   = shiftReg;
    divisorRegNext = divisorReg;
    quotNext       = quotient;
    remNext        = remainder;
    dbzNext        = div_by_zero;

    unique case (state)
      IDLE: begin
        if (start) begin
          stepCntNext    = '0;
          partRemNext    = '0;
          shiftRegNext   = dividend;
          divisorRegNext = divisor;
          if (divisor == '0) begin
            quotNext  = '1;
            remNext   = dividend;
            dbzNext   = 1'b1;
            stateNext = DONE;
          end else begin
            stateNext = CALC;
          end
        end
      end
      CALC: begin
        partRemNext  = newRem;
        shiftRegNext = newShift;
        stepCntNext  = stepCnt + 1'b1;
        if (stepCnt == LastStep) begin
          quotNext  = newShift;
          remNext   = newRem;
          dbzNext   = 1'b0;
          stateNext = DONE;
        end
      end
      DONE: begin
        stateNext = IDLE;
      end
      default: begin
        stateNext = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      stepCnt     <= '0;
      partRem     <= '0;
      shiftReg    <= '0;
      divisorReg  <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= stateNext;
      stepCnt     <= stepCntNext;
      partRem     <= partRemNext;
      shiftReg    <= shiftRegNext;
      divisorReg  <= divisorRegNext;
      quotient    <= quotNext;
      remainder   <= remNext;
      div_by_zero <= dbzNext;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_seq_divider.sv
// Scoreboard bench for seq_divider (WIDTH=4): driver queues expectations, monitor checks on done.
module tb_seq_divider;

  localparam int W = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;

  typedef struct {
    int q;
    int r;
    int dbz;
    int doneCyc;
  } expEntry_t;

  expEntry_t sb[$];
  int nCmp = 0;
  int nBad = 0;
  int cyc  = 0;

  seq_divider #(
    .WIDTH (W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int got, input int want);
    nCmp++;
    if (got != want) begin
      nBad++;
      $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    end
  endtask

  // Monitor: every done pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (done) begin
      if (sb.size() == 0) begin
        check("unexpectedDone", 1, 0);
      end else begin
        expEntry_t e;
        e = sb.pop_front();
        check("quotient", int'(quotient), e.q);
        check("remainder", int'(remainder), e.r);
        check("div_by_zero", int'(div_by_zero), e.dbz);
        check("doneCycle", cyc, e.doneCyc);
      end
    end
  end

  task automatic runDiv(input int a, input int b, input int q, input int r, input int dbz);
    int busyCnt;
    int seen;
    int lat;
    lat = (b == 0) ? 1 : W + 1;
    @(negedge clk);
    dividend = W'(a);
    divisor  = W'(b);
    start    = 1'b1;
    sb.push_back('{q, r, dbz, cyc + lat});
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    busyCnt  = 0;
    seen     = 0;
    for (int i = 0; i < 20 && seen == 0; i++) begin
      @(negedge clk);
      if (busy) busyCnt++;
      if (done) seen = 1;
    end
    check("doneSeen", seen, 1);
    check("busyCycles", busyCnt, (b == 0) ? 0 : W);
  endtask

  task automatic checkIdleZero(input string tag);
    check({tag, ".busy"}, int'(busy), 0);
    check({tag, ".done"}, int'(done), 0);
    check({tag, ".quotient"}, int'(quotient), 0);
    check({tag, ".remainder"}, int'(remainder), 0);
    check({tag, ".div_by_zero"}, int'(div_by_zero), 0);
  endtask

  task automatic expectNoDone(input string tag, input int cycles);
    int seen;
    seen = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (done || busy) seen = 1;
    end
    check(tag, seen, 0);
  endtask

  initial begin
    rst      = 1'b1;
    start    = 1'b1;
    dividend = 4'd5;
    divisor  = 4'd1;
    repeat (3) @(posedge clk);
    #1;
    rst   = 1'b0;
    start = 1'b0;
    @(negedge clk);
    checkIdleZero("reset");
    expectNoDone("startDuringReset", 6);

    runDiv(13, 3, 4, 1, 0);
    runDiv(15, 1, 15, 0, 0);
    runDiv(15, 15, 1, 0, 0);
    runDiv(2, 7, 0, 2, 0);
    runDiv(9, 0, 15, 9, 1);
    runDiv(8, 2, 4, 0, 0);

    // Start 12/5, then a second start in cycle 2 must be ignored.
    @(negedge clk);
    dividend = 4'd12;
    divisor  = 4'd5;
    start    = 1'b1;
    sb.push_back('{2, 2, 0, cyc + W + 1});
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    dividend = 4'd1;
    divisor  = 4'd1;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    expectNoDone("ignoredStartDrains", 0);
    begin
      int seen;
      seen = 0;
      for (int i = 0; i < 10 && seen == 0; i++) begin
        @(negedge clk);
        if (done) seen = 1;
      end
      check("ignoredStart.doneSeen", seen, 1);
    end
    expectNoDone("ignoredStart.noSecond", 8);

    // Reset in cycle 2 of 13/3 aborts it without a done pulse.
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkIdleZero("midCalcReset");
    expectNoDone("midCalcReset.noDone", 8);
    runDiv(6, 4, 1, 2, 0);

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        if (b == 0) runDiv(a, 0, 15, a, 1);
        else        runDiv(a, b, a / b, a % b, 0);
      end
    end

    repeat (3) @(negedge clk);
    check("scoreboardDrained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
